// File: rtl/mem_indirect_sequencer_pkg.sv
// Shared LC-3b types for the MEM-stage data-memory sequencer:
// opcode encoding, sequencer state enum and opcode classification helpers.
package mem_indirect_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'ha,
    OP_STI  = 4'hb,
    OP_JMP  = 4'hc,
    OP_SHF  = 4'hd,
    OP_LEA  = 4'he,
    OP_TRAP = 4'hf
  } lc3b_opcode;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR_RD = 2'd1,
    DATA   = 2'd2,
    DONE   = 2'd3
  } mem_seq_state_t;

  function automatic logic is_mem_op(input lc3b_opcode op);
    case (op)
      OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI, OP_TRAP: is_mem_op = 1'b1;
      default:                                                is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_indirect(input lc3b_opcode op);
    is_indirect = (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_store(input lc3b_opcode op);
    is_store = (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/mem_indirect_sequencer_dmem_lane_align.sv
// Combinational byte-lane steering between the sequencer and D-mem:
// STB data replication and lane enable, LDB byte extraction with zero-extension.
module dmem_lane_align
  import mem_indirect_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [3:0]          op,
  input  logic [LANE_W-1:0]   lane,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   wdata_out,
  output logic [DATA_W-1:0]   rdata_out
);

  localparam int NBYTES = DATA_W / 8;

  always_comb begin
    wdata_out = wdata;
    byte_en   = '1;
    rdata_out = rdata;
    if (op == OP_STB) begin
      wdata_out = {NBYTES{wdata[7:0]}};
      byte_en   = NBYTES'(1) << lane;
    end
    if (op == OP_LDB) begin
      rdata_out = DATA_W'(8'(rdata >> {lane, 3'b000}));
    end
  end

endmodule

// File: rtl/mem_indirect_sequencer.sv
// MEM-stage data-memory sequencer: one D-mem access per word/byte/TRAP op, two
// chained accesses (pointer, then data) for LDI/STI, stalling upstream stages meanwhile.
module mem_indirect_sequencer
  import mem_indirect_sequencer_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int NUM_STAGES = 4,
  parameter int WAIT_MAX   = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  lc3b_opcode            req_op,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic [DATA_W/8-1:0]   dmem_byte_en,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_resp,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [NUM_STAGES-1:0] load_stage,
  output logic                  busy,
  output logic                  timeout_err,
  output mem_seq_state_t        dbg_state
);

  // Handshake: dmem_read/dmem_write stay high until the cycle dmem_resp is seen;
  // rsp_valid is a single-cycle pulse with no back-pressure from MEM/WB.

  localparam int NBYTES = DATA_W / 8;
  localparam int LANE_W = $clog2(NBYTES);
  localparam int CNT_W  = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int LIMIT  = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;

  mem_seq_state_t    state;
  lc3b_opcode        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              accept;
  logic              timed_out;
  logic [NBYTES-1:0] lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

  assign accept    = req_valid && is_mem_op(req_op);
  assign timed_out = (WAIT_MAX != 0) && (wait_cnt == CNT_W'(LIMIT));

  // The data phase of LDI/STI goes to the pointer fetched in PTR_RD.
  assign dmem_addr = (state == DATA && is_indirect(op_q)) ? ptr_q : addr_q;

  dmem_lane_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_align (
    .op        (op_q),
    .lane      (dmem_addr[LANE_W-1:0]),
    .wdata     (wdata_q),
    .rdata     (dmem_rdata),
    .byte_en   (lane_be),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  assign dmem_wdata   = lane_wdata;
  assign dmem_byte_en = dmem_write ? lane_be : '0;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

  always_comb begin
    case (state)
      IDLE:    load_stage = ~{NUM_STAGES{accept}};
      DONE:    load_stage = '1;
      default: load_stage = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_q        <= OP_BR;
      addr_q      <= '0;
      ptr_q       <= '0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      dmem_read   <= 1'b0;
      dmem_write  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= req_op;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            ptr_q    <= '0;
            wait_cnt <= '0;
            if (is_indirect(req_op)) begin
              dmem_read <= 1'b1;
              state     <= PTR_RD;
            end else begin
              dmem_read  <= !is_store(req_op);
              dmem_write <= is_store(req_op);
              state      <= DATA;
            end
          end
        end
        PTR_RD, DATA: begin
          // A response in the limit cycle still completes normally.
          if (dmem_resp) begin
            wait_cnt <= '0;
            if (state == PTR_RD) begin
              ptr_q      <= ADDR_W'(dmem_rdata);
              dmem_read  <= !is_store(op_q);
              dmem_write <= is_store(op_q);
              state      <= DATA;
            end else begin
              dmem_read  <= 1'b0;
              dmem_write <= 1'b0;
              rsp_valid  <= 1'b1;
              if (!is_store(op_q)) begin
                rsp_rdata <= lane_rdata;
              end
              state <= DONE;
            end
          end else if (timed_out) begin
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_indirect_sequencer.sv
// Self-checking bench for mem_indirect_sequencer: directed scenarios plus a randomized
// mix of memory ops checked against a word-array memory model and expected queue.
module tb_mem_indirect_sequencer;
  import mem_indirect_sequencer_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int NS     = 4;
  localparam int WMAX   = 4;

  logic              clk;
  logic              reset_n;
  lc3b_opcode        req_op;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [1:0]        dmem_byte_en;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_resp;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [NS-1:0]     load_stage;
  logic              busy;
  logic              timeout_err;
  mem_seq_state_t    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] tb_mem [0:32767];
  logic [15:0] ref_mem [0:255];
  logic [DATA_W-1:0] exp_q[$];

  logic [15:0] log_addr[$];
  logic [15:0] log_wdata[$];
  logic [1:0]  log_be[$];
  bit          log_wr[$];
  int          log_dly[$];

  int fix_delay = 0;
  bit no_resp   = 1'b0;
  bit active    = 1'b0;
  int waited    = 0;
  int cur_delay = 0;
  int rwi       = 0;

  lc3b_opcode mem_ops [7] = '{OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI, OP_TRAP};
  lc3b_opcode pt_ops  [6] = '{OP_ADD, OP_AND, OP_BR, OP_JMP, OP_LEA, OP_SHF};

  mem_indirect_sequencer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_STAGES (NS),
    .WAIT_MAX   (WMAX)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_op       (req_op),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_byte_en (dmem_byte_en),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .load_stage   (load_stage),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // D-mem responder: answers each access after cur_delay wait cycles
  initial begin
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      dmem_resp  = 1'b0;
      dmem_rdata = 16'($urandom);
      if (reset_n !== 1'b1 || (dmem_read !== 1'b1 && dmem_write !== 1'b1)) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active    = 1'b1;
          waited    = 0;
          cur_delay = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
        end
        if (!no_resp && waited == cur_delay) begin
          rwi        = int'(dmem_addr[15:1]);
          dmem_resp  = 1'b1;
          dmem_rdata = tb_mem[rwi];
          if (dmem_write === 1'b1) begin
            if (dmem_byte_en[0]) tb_mem[rwi][7:0]  = dmem_wdata[7:0];
            if (dmem_byte_en[1]) tb_mem[rwi][15:8] = dmem_wdata[15:8];
          end
          log_addr.push_back(dmem_addr);
          log_wdata.push_back(dmem_wdata);
          log_be.push_back(dmem_byte_en);
          log_wr.push_back(dmem_write);
          log_dly.push_back(cur_delay);
          active = 1'b0;
        end else begin
          waited++;
        end
      end
    end
  end

  // driver: issue one request, follow it to rsp_valid while feeding junk on req_*
  task automatic do_op(input lc3b_opcode op, input logic [15:0] addr, input logic [15:0] wdata,
                       output int cycles, output logic [15:0] rdata, output bit got,
                       output bit stall_ok, output logic [NS-1:0] done_ls, output logic after_busy);
    log_addr.delete(); log_wdata.delete(); log_be.delete(); log_wr.delete(); log_dly.delete();
    got = 1'b0; rdata = '0; done_ls = '0; cycles = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    #1;
    stall_ok = (load_stage === '0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1; rdata = rsp_rdata; done_ls = load_stage; cycles = c;
        break;
      end
      if (load_stage !== '0) stall_ok = 1'b0;
      req_valid = 1'b1;
      req_op    = mem_ops[$urandom_range(0, 6)];
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    after_busy = busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_op = OP_BR; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: busy=%b state=%0d want busy=0 state=0", busy, dbg_state); end
    total++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin bad++; $display("FAIL reset_strobes: rd=%b wr=%b want 0 0", dmem_read, dmem_write); end
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0) begin bad++; $display("FAIL reset_rsp: valid=%b rdata=%h want 0 0000", rsp_valid, rsp_rdata); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    total++; if (load_stage !== 4'hf) begin bad++; $display("FAIL reset_load_stage: got %h want f", load_stage); end
    total++; if (dmem_byte_en !== 2'b00) begin bad++; $display("FAIL reset_byte_en: got %b want 00", dmem_byte_en); end
  endtask

  task automatic test_ldr();
    int cyc; logic [15:0] rd; bit got, st; logic [NS-1:0] ls; logic ab;
    tb_mem[16'h0040 >> 1] = 16'hbeef;
    fix_delay = 3;
    do_op(OP_LDR, 16'h0040, 16'h0, cyc, rd, got, st, ls, ab);
    total++; if (!got) begin bad++; $display("FAIL ldr_got: no rsp_valid within bound"); end
    total++; if (cyc !== 5) begin bad++; $display("FAIL ldr_latency: got %0d want 5", cyc); end
    total++; if (rd !== 16'hbeef) begin bad++; $display("FAIL ldr_rdata: got %h want beef", rd); end
    total++; if (!st) begin bad++; $display("FAIL ldr_stall: load_stage not 0 during cycles 0-4"); end
    total++; if (ls !== 4'hf) begin bad++; $display("FAIL ldr_done_ls: got %h want f", ls); end
    total++; if (log_addr.size() != 1 || log_addr[0] !== 16'h0040 || log_wr[0] !== 1'b0)
      begin bad++; $display("FAIL ldr_access: n=%0d want one read at 0040", log_addr.size()); end
    total++; if (ab !== 1'b0) begin bad++; $display("FAIL ldr_done_accept: busy=%b after DONE want 0", ab); end
  endtask

  task automatic test_ldi();
    int cyc; logic [15:0] rd; bit got, st; logic [NS-1:0] ls; logic ab;
    tb_mem[16'h0100 >> 1] = 16'h0200;
    tb_mem[16'h0200 >> 1] = 16'h1234;
    fix_delay = 1;
    do_op(OP_LDI, 16'h0100, 16'h0, cyc, rd, got, st, ls, ab);
    total++; if (rd !== 16'h1234 || !got) begin bad++; $display("FAIL ldi_rdata: got %h want 1234", rd); end
    total++; if (cyc !== 5) begin bad++; $display("FAIL ldi_latency: got %0d want 5", cyc); end
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL ldi_count: got %0d accesses want 2", log_addr.size()); end
    else begin
      total++; if (log_addr[0] !== 16'h0100 || log_addr[1] !== 16'h0200 || log_wr[0] || log_wr[1])
        begin bad++; $display("FAIL ldi_addrs: got %h,%h want reads 0100,0200", log_addr[0], log_addr[1]); end
    end
    total++; if (!st) begin bad++; $display("FAIL ldi_stall: load_stage not 0 while busy"); end
  endtask

  task automatic test_byte();
    int cyc; logic [15:0] rd; bit got, st; logic [NS-1:0] ls; logic ab;
    tb_mem[16'h0031 >> 1] = 16'h1111;
    fix_delay = 0;
    do_op(OP_STB, 16'h0031, 16'h00ab, cyc, rd, got, st, ls, ab);
    total++; if (cyc !== 2 || !got) begin bad++; $display("FAIL stb_latency: got %0d want 2", cyc); end
    total++; if (log_addr.size() != 1) begin bad++; $display("FAIL stb_count: got %0d want 1", log_addr.size()); end
    else begin
      total++; if (log_wdata[0] !== 16'habab || log_be[0] !== 2'b10 || log_wr[0] !== 1'b1 || log_addr[0] !== 16'h0031)
        begin bad++; $display("FAIL stb_bus: wdata=%h be=%b wr=%b addr=%h want abab 10 1 0031", log_wdata[0], log_be[0], log_wr[0], log_addr[0]); end
    end
    total++; if (tb_mem[16'h0031 >> 1] !== 16'hab11) begin bad++; $display("FAIL stb_mem: got %h want ab11", tb_mem[16'h0031 >> 1]); end
    tb_mem[16'h0031 >> 1] = 16'hcd00;
    do_op(OP_LDB, 16'h0031, 16'h0, cyc, rd, got, st, ls, ab);
    total++; if (rd !== 16'h00cd || !got) begin bad++; $display("FAIL ldb_rdata: got %h want 00cd", rd); end
  endtask

  task automatic test_sti();
    int cyc; logic [15:0] rd; bit got, st; logic [NS-1:0] ls; logic ab;
    tb_mem[16'h0010 >> 1] = 16'h0300;
    tb_mem[16'h0300 >> 1] = 16'h0000;
    fix_delay = 2;
    do_op(OP_STI, 16'h0010, 16'h5a5a, cyc, rd, got, st, ls, ab);
    total++; if (cyc !== 7 || !got) begin bad++; $display("FAIL sti_latency: got %0d want 7", cyc); end
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL sti_count: got %0d want 2", log_addr.size()); end
    else begin
      total++; if (log_addr[1] !== 16'h0300 || log_wr[1] !== 1'b1 || log_be[1] !== 2'b11 || log_wdata[1] !== 16'h5a5a)
        begin bad++; $display("FAIL sti_bus: addr=%h wr=%b be=%b wdata=%h want 0300 1 11 5a5a", log_addr[1], log_wr[1], log_be[1], log_wdata[1]); end
    end
    total++; if (rd !== 16'h00cd) begin bad++; $display("FAIL sti_rdata_hold: got %h want 00cd", rd); end
    total++; if (tb_mem[16'h0300 >> 1] !== 16'h5a5a) begin bad++; $display("FAIL sti_mem: got %h want 5a5a", tb_mem[16'h0300 >> 1]); end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = pt_ops[i]; req_addr = 16'($urandom); req_wdata = 16'($urandom);
      #1;
      total++; if (load_stage !== 4'hf) begin bad++; $display("FAIL pass_load_stage: op=%0d got %h want f", pt_ops[i], load_stage); end
      @(negedge clk);
      total++; if (busy !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0 || rsp_valid !== 1'b0)
        begin bad++; $display("FAIL pass_idle: op=%0d busy=%b rd=%b wr=%b rv=%b want 0000", pt_ops[i], busy, dmem_read, dmem_write, rsp_valid); end
      req_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    int cyc, wi, pi, lat_exp, diffs; logic [15:0] rd, addr, wdata, p, expv, last; bit got, st, ind;
    logic [NS-1:0] ls; logic ab; lc3b_opcode op;
    for (int w = 0; w < 256; w++) begin
      ref_mem[w] = (w < 16) ? 16'h0100 + 16'(2 * $urandom_range(0, 127)) : 16'($urandom);
      tb_mem[w]  = ref_mem[w];
    end
    fix_delay = -1;
    last = 16'h00cd;
    for (int n = 0; n < 40; n++) begin
      op    = mem_ops[$urandom_range(0, 6)];
      wdata = 16'($urandom);
      case (op)
        OP_LDB, OP_STB: addr = 16'h0100 + 16'($urandom_range(0, 255));
        OP_LDI, OP_STI: addr = 16'(2 * $urandom_range(0, 15));
        default:        addr = 16'h0100 + 16'(2 * $urandom_range(0, 127));
      endcase
      wi   = int'(addr >> 1);
      p    = ref_mem[wi];
      pi   = int'(p >> 1);
      ind  = (op == OP_LDI) || (op == OP_STI);
      expv = last;
      case (op)
        OP_LDR, OP_TRAP: expv = ref_mem[wi];
        OP_LDB:          expv = {8'h00, addr[0] ? ref_mem[wi][15:8] : ref_mem[wi][7:0]};
        OP_LDI:          expv = ref_mem[pi];
        OP_STR:          ref_mem[wi] = wdata;
        OP_STI:          ref_mem[pi] = wdata;
        OP_STB:          if (addr[0]) ref_mem[wi][15:8] = wdata[7:0]; else ref_mem[wi][7:0] = wdata[7:0];
        default:         expv = last;
      endcase
      last = expv;
      exp_q.push_back(expv);
      do_op(op, addr, wdata, cyc, rd, got, st, ls, ab);
      lat_exp = ind ? 3 : 2;
      foreach (log_dly[k]) lat_exp += log_dly[k];
      total++; if (!got || rd !== exp_q.pop_front()) begin bad++; $display("FAIL rand_rdata: n=%0d op=%0d addr=%h got %h want %h", n, op, addr, rd, expv); end
      total++; if (cyc !== lat_exp) begin bad++; $display("FAIL rand_latency: n=%0d op=%0d got %0d want %0d", n, op, cyc, lat_exp); end
      total++; if (!st || ls !== 4'hf || ab !== 1'b0) begin bad++; $display("FAIL rand_stall: n=%0d stall_ok=%b done_ls=%h busy_after=%b", n, st, ls, ab); end
      if (ind) begin
        total++; if (log_addr.size() != 2 || log_addr[log_addr.size() - 1] !== p)
          begin bad++; $display("FAIL rand_ptr_addr: n=%0d accesses=%0d want 2 with data addr %h", n, log_addr.size(), p); end
      end
    end
    diffs = 0;
    for (int w = 128; w < 256; w++) if (tb_mem[w] !== ref_mem[w]) diffs++;
    total++; if (diffs != 0) begin bad++; $display("FAIL rand_mem_image: %0d words differ want 0", diffs); end
  endtask

  task automatic test_timeout();
    int cyc; logic [15:0] rd; bit got, st; logic [NS-1:0] ls; logic ab;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_pre: got %b want 0", timeout_err); end
    no_resp = 1'b1;
    do_op(OP_LDR, 16'h0040, 16'h0, cyc, rd, got, st, ls, ab);
    total++; if (!got || cyc !== WMAX + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", cyc, WMAX + 1); end
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL to_rdata: got %h want 0000", rd); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    no_resp = 1'b0;
    fix_delay = 0;
    tb_mem[16'h0040 >> 1] = 16'hbeef;
    do_op(OP_LDR, 16'h0040, 16'h0, cyc, rd, got, st, ls, ab);
    total++; if (rd !== 16'hbeef || cyc !== 2) begin bad++; $display("FAIL to_recover: rdata=%h cyc=%0d want beef 2", rd, cyc); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_mid_reset();
    no_resp = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LDI; req_addr = 16'h0010;
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (busy !== 1'b1 || dmem_read !== 1'b1 || dbg_state !== PTR_RD)
      begin bad++; $display("FAIL mr_ptr_rd: busy=%b rd=%b state=%0d want 1 1 1", busy, dmem_read, dbg_state); end
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || dmem_read !== 1'b0 || dbg_state !== IDLE)
      begin bad++; $display("FAIL mr_abort: busy=%b rd=%b state=%0d want 0 0 0", busy, dmem_read, dbg_state); end
    total++; if (timeout_err !== 1'b0 || rsp_rdata !== 16'h0) begin bad++; $display("FAIL mr_clear: to=%b rdata=%h want 0 0000", timeout_err, rsp_rdata); end
    reset_n = 1'b1;
    no_resp = 1'b0;
    req_valid = 1'b1; req_op = OP_ADD;
    #1;
    total++; if (load_stage !== 4'hf) begin bad++; $display("FAIL mr_add_ls: got %h want f", load_stage); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL mr_add_idle: busy=%b rv=%b want 0 0", busy, rsp_valid); end
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) tb_mem[i] = '0;
    test_reset();
    test_ldr();
    test_ldi();
    test_byte();
    test_sti();
    test_passthrough();
    test_random();
    test_timeout();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
